// File: rtl/load_store_unit_pkg.sv
// load_store_unit shared definitions: access sizes,
// FSM states and the request legality check.
package load_store_unit_pkg;

    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        CAPTURE = 2'b10,
        WRITE   = 2'b11
    } lsu_state_e;

    // 1 when the size is illegal or the address is not naturally aligned
    function automatic logic lsu_bad_req(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        return (size == 2'b11)
            || (size == LSU_HALF && lane[0])
            || (size == LSU_WORD && lane != 2'b00);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit request/response and data memory bus.
// slave = LSU side, master = execute stage plus memory.
interface load_store_unit_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size,
        input  req_signed, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        output mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_write, req_size,
        output req_signed, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        input  mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane handling: load extract/extend and
// sub-word store merge into the old memory word.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] ldata,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    output logic [31:0] mdata
);

    logic [7:0]  lb;
    logic [15:0] lh;

    // Select the addressed lane and extend it to 32 bits
    always_comb begin
        lb = word[{addr, 3'b000} +: 8];
        lh = addr[1] ? word[31:16] : word[15:0];
        ldata = word;
        unique case (1'b1)
            (size == LSU_BYTE): ldata = {{24{sign_ext & lb[7]}}, lb};
            (size == LSU_HALF): ldata = {{16{sign_ext & lh[15]}}, lh};
            default:            ldata = word;
        endcase
    end

    // Overlay the store bytes on the word read back from memory
    always_comb begin
        mdata = old_word;
        unique case (1'b1)
            (size == LSU_BYTE):
                mdata[{addr, 3'b000} +: 8] = new_data[7:0];
            (size == LSU_HALF):
                if (addr[1]) mdata[31:16] = new_data[15:0];
                else         mdata[15:0]  = new_data[15:0];
            default:
                mdata = new_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word memory.
// One request at a time; sub-word stores are read-modify-write.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input logic               clk,
    input logic               reset,
    load_store_unit_if.slave  bus
);

    lsu_state_e        state;
    logic              r_write;
    logic              r_signed;
    logic [1:0]        r_size;
    logic [1:0]        r_lane;
    logic [31:0]       r_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              accept;
    logic              bad;
    logic              wstore;
    logic [31:0]       ld_data;
    logic [31:0]       st_data;

    assign bus.req_ready = reset && (state == IDLE);
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_error = rsp_error;
    assign bus.mem_write = mem_write;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

    assign accept = bus.req_valid && bus.req_ready;
    assign bad    = lsu_bad_req(bus.req_size, bus.req_addr[1:0]);
    assign wstore = bus.req_write && (bus.req_size == LSU_WORD);

    lsu_lane_align u_align (
        .word     (bus.mem_rdata),
        .addr     (r_lane),
        .size     (r_size),
        .sign_ext (r_signed),
        .ldata    (ld_data),
        .old_word (bus.mem_rdata),
        .new_data (r_wdata),
        .mdata    (st_data)
    );

    // Request FSM with registered memory and response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            r_write   <= 1'b0;
            r_signed  <= 1'b0;
            r_size    <= 2'b00;
            r_lane    <= 2'b00;
            r_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        r_write  <= bus.req_write;
                        r_signed <= bus.req_signed;
                        r_size   <= bus.req_size;
                        r_lane   <= bus.req_addr[1:0];
                        r_wdata  <= bus.req_wdata;
                        if (bad) begin
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            mem_addr <= bus.req_addr[ADDR_W+1:2];
                            if (wstore) begin
                                mem_write <= 1'b1;
                                mem_wdata <= bus.req_wdata;
                            end
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (r_write && r_size == LSU_WORD) begin
                        mem_write <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (r_write) begin
                        mem_wdata <= st_data;
                        mem_write <= 1'b1;
                        state     <= WRITE;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= ld_data;
                        state     <= IDLE;
                    end
                end
                WRITE: begin
                    mem_write <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_error <= 1'b0;
                    rsp_rdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
